// File: rtl/if_id_fetch_ctrl.sv
// Front-end fetch controller: owns the PC and IF/ID register, applies hazard
// stall/flush decisions, and parks redirects that arrive during an I-cache miss.
module if_id_fetch_ctrl #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [31:0]      NOP_INST = 32'h0000_0013,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             hazard_flush,
    input  logic             hazard_mux,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic [31:0]      icache_rdata,
    output logic [XLEN-1:0]  pc,
    output logic             icache_ren,
    output logic [31:0]      IF_ID_inst,
    output logic [XLEN-1:0]  IF_ID_pc,
    output logic             IF_ID_valid,
    output logic             ID_EX_bubble,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic {RUN, DISCARD} state_t;

    state_t           state_q,      state_d;
    logic [XLEN-1:0]  pc_q,         pc_d;
    logic [XLEN-1:0]  pending_pc_q, pending_pc_d;
    logic [31:0]      if_id_inst_q, if_id_inst_d;
    logic [XLEN-1:0]  if_id_pc_q,   if_id_pc_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic             icache_ren_q, icache_ren_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [XLEN-1:0]  target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign target = hazard_mux ? branch_target : jump_target;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_pc_d  = pending_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        icache_ren_d  = 1'b1;
        flush_cnt_d   = flush_cnt_q;
        bubble_cnt_d  = bubble_cnt_q;

        if (!dcache_stall) begin
            unique case (state_q)
                RUN: begin
                    if (hazard_stall) begin
                        bubble_cnt_d = sat_inc(bubble_cnt_q);
                    end else if (hazard_flush) begin
                        if_id_inst_d  = NOP_INST;
                        if_id_valid_d = 1'b0;
                        flush_cnt_d   = sat_inc(flush_cnt_q);
                        if (icache_stall) begin
                            pending_pc_d = target;
                            state_d      = DISCARD;
                        end else begin
                            pc_d = target;
                        end
                    end else if (icache_stall) begin
                        if_id_inst_d  = NOP_INST;
                        if_id_valid_d = 1'b0;
                    end else begin
                        if_id_inst_d  = icache_rdata;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_q + XLEN'(4);
                    end
                end
                DISCARD: begin
                    if (hazard_stall) begin
                        bubble_cnt_d = sat_inc(bubble_cnt_q);
                    end else if (hazard_flush) begin
                        pending_pc_d = target;
                        flush_cnt_d  = sat_inc(flush_cnt_q);
                    end
                    if_id_inst_d  = NOP_INST;
                    if_id_valid_d = 1'b0;
                    // Miss resolved: drop the stale word and resume at the newest target.
                    if (!icache_stall) begin
                        pc_d    = pending_pc_d;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pending_pc_q  <= '0;
            if_id_inst_q  <= NOP_INST;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
            icache_ren_q  <= 1'b0;
            flush_cnt_q   <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_pc_q  <= pending_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
            icache_ren_q  <= icache_ren_d;
            flush_cnt_q   <= flush_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign pc           = pc_q;
    assign icache_ren   = icache_ren_q;
    assign IF_ID_inst   = if_id_inst_q;
    assign IF_ID_pc     = if_id_pc_q;
    assign IF_ID_valid  = if_id_valid_q;
    assign ID_EX_bubble = hazard_stall & ~dcache_stall;
    assign flush_cnt    = flush_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// Self-checking bench for if_id_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_if_id_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned CMAX = 65535;

    logic        clk;
    logic        rst_n;
    logic        hazard_stall, hazard_flush, hazard_mux;
    logic [31:0] branch_target, jump_target;
    logic        icache_stall, dcache_stall;
    logic [31:0] icache_rdata;
    logic [31:0] pc;
    logic        icache_ren;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;
    logic        ID_EX_bubble;
    logic [15:0] flush_cnt, bubble_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc, m_inst, m_ifpc, m_pend;
    logic        m_valid, m_disc, m_ren;
    int unsigned m_fc, m_bc;

    if_id_fetch_ctrl #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hazard_stall(hazard_stall), .hazard_flush(hazard_flush), .hazard_mux(hazard_mux),
        .branch_target(branch_target), .jump_target(jump_target),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall), .icache_rdata(icache_rdata),
        .pc(pc), .icache_ren(icache_ren),
        .IF_ID_inst(IF_ID_inst), .IF_ID_pc(IF_ID_pc), .IF_ID_valid(IF_ID_valid),
        .ID_EX_bubble(ID_EX_bubble), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Applies the front-end rules to the inputs present at this clock edge.
    task automatic model_edge();
        logic [31:0] tgt;
        tgt = hazard_mux ? branch_target : jump_target;
        if (!rst_n) begin
            m_pc = 32'h0; m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
            m_disc = 1'b0; m_pend = 32'h0; m_fc = 0; m_bc = 0; m_ren = 1'b0;
            return;
        end
        m_ren = 1'b1;
        if (dcache_stall) return;
        if (!m_disc) begin
            if (hazard_stall) begin
                m_bc = sat(m_bc);
            end else if (hazard_flush) begin
                m_inst = NOP; m_valid = 1'b0; m_fc = sat(m_fc);
                if (icache_stall) begin m_pend = tgt; m_disc = 1'b1; end
                else m_pc = tgt;
            end else if (icache_stall) begin
                m_inst = NOP; m_valid = 1'b0;
            end else begin
                m_inst = icache_rdata; m_ifpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else begin
            if (hazard_stall) m_bc = sat(m_bc);
            else if (hazard_flush) begin m_pend = tgt; m_fc = sat(m_fc); end
            m_inst = NOP; m_valid = 1'b0;
            if (!icache_stall) begin m_pc = m_pend; m_disc = 1'b0; end
        end
    endtask

    task automatic check_all();
        chk("pc",          pc,          m_pc);
        chk("IF_ID_inst",  IF_ID_inst,  m_inst);
        chk("IF_ID_pc",    IF_ID_pc,    m_ifpc);
        chk("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
        chk("icache_ren",  {31'b0, icache_ren},  {31'b0, m_ren});
        chk("flush_cnt",   {16'b0, flush_cnt},   m_fc);
        chk("bubble_cnt",  {16'b0, bubble_cnt},  m_bc);
    endtask

    // One clock: drive on the falling edge, check the combinational bubble,
    // advance the model on the rising edge, then check registered outputs.
    task automatic cyc(input logic r, input logic hs, input logic hf, input logic mx,
                       input logic [31:0] bt, input logic [31:0] jt,
                       input logic ics, input logic dcs, input logic [31:0] rd);
        @(negedge clk);
        rst_n = r; hazard_stall = hs; hazard_flush = hf; hazard_mux = mx;
        branch_target = bt; jump_target = jt; icache_stall = ics;
        dcache_stall = dcs; icache_rdata = rd;
        #1 chk("ID_EX_bubble", {31'b0, ID_EX_bubble}, {31'b0, hs & ~dcs});
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    localparam logic [31:0] RD = 32'h00A0_0093;

    initial begin
        m_pc = '0; m_inst = NOP; m_ifpc = '0; m_pend = '0;
        m_valid = 1'b0; m_disc = 1'b0; m_ren = 1'b0; m_fc = 0; m_bc = 0;
        rst_n = 1'b0; hazard_stall = 1'b0; hazard_flush = 1'b0; hazard_mux = 1'b0;
        branch_target = '0; jump_target = '0; icache_stall = 1'b0;
        dcache_stall = 1'b0; icache_rdata = RD;

        // reset
        cyc(0, 0, 0, 0, 0, 0, 0, 0, RD);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, RD);
        chk("reset_pc", pc, 32'h0);
        chk("reset_ren", {31'b0, icache_ren}, 32'h0);

        // free run: pc 0 -> 4 -> 8
        cyc(1, 0, 0, 0, 0, 0, 0, 0, RD);
        chk("first_fetch_ifpc", IF_ID_pc, 32'h0);
        chk("first_fetch_valid", {31'b0, IF_ID_valid}, 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, RD);
        chk("pc_8", pc, 32'h8);

        // load-use stall at pc=8
        cyc(1, 1, 0, 0, 0, 0, 0, 0, RD);
        chk("stall_pc_hold", pc, 32'h8);
        chk("stall_bubble_cnt", {16'b0, bubble_cnt}, 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, RD);
        chk("pc_C", pc, 32'hC);

        // branch redirect, no I-cache miss
        cyc(1, 0, 1, 1, 32'h100, 32'h0, 0, 0, RD);
        chk("redirect_pc", pc, 32'h100);
        chk("redirect_inst", IF_ID_inst, NOP);

        // redirects during an I-cache miss: latest target wins
        cyc(1, 0, 1, 0, 32'h0, 32'h200, 1, 0, 32'hDEAD_BEEF);
        cyc(1, 0, 1, 1, 32'h300, 32'h0, 1, 0, 32'hDEAD_BEEF);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'hBAD0_BAD0);
        chk("discard_pc", pc, 32'h300);
        chk("discard_drop", {31'b0, IF_ID_valid}, 32'h0);
        chk("discard_flush_cnt", {16'b0, flush_cnt}, 32'h3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, RD);
        chk("post_discard_ifpc", IF_ID_pc, 32'h300);

        // D-cache freeze swallows a flush and a stall
        cyc(1, 0, 1, 1, 32'h500, 32'h0, 0, 1, RD);
        cyc(1, 1, 1, 0, 32'h0, 32'h600, 0, 1, RD);
        chk("freeze_pc", pc, 32'h304);

        // bubble counter saturation
        for (int i = 0; i < 65533; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, RD);
        chk("bubble_fffe", {16'b0, bubble_cnt}, 32'hFFFE);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, RD);
        chk("bubble_sat", {16'b0, bubble_cnt}, 32'hFFFF);

        // pc wrap
        cyc(1, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 0, 0, RD);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, RD);
        chk("pc_wrap", pc, 32'h0);

        // reset in the middle of DISCARD
        cyc(1, 0, 1, 1, 32'h700, 32'h0, 1, 0, RD);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, RD);
        chk("discard_reset_pc", pc, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, RD);
        chk("discard_reset_run", pc, 32'h4);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 4) == 0),
                1'($urandom),
                $urandom, $urandom,
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 6) == 0),
                $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
